cpu_read_con: RTL and testbench
===============================

CPU_READ_CON -- requirements
Module: cpu_read_con

Interface
REQ-001 SHALL have parameter VERSION, default 32'h0000_0100: constant returned at address 16.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk and nRST.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 nRST  input  1  asynchronous active-low reset.
REQ-005 cpu_rd_n  input  1  NIOS read strobe, active low, may be held low for several cycles.
REQ-006 cpu_addr  input  9  NIOS word address.
REQ-007 cpu_rdata  output  32  registered read data.
REQ-008 cpu_rdata_valid  output  1  one-cycle pulse marking cpu_rdata valid.
REQ-009 irq  output  1  high while any sticky status bit is set.
REQ-010 mac_tx_done  input  1  one-cycle pulse, UDP packet sent.
REQ-011 sdram_wr_done  input  1  one-cycle pulse, SDRAM write window complete.
REQ-012 sdram_rd_done  input  1  one-cycle pulse, SDRAM read window complete.
REQ-013 err_in  input  1  one-cycle pulse, datapath error.
REQ-014 sdram_wr_ptr  input  16  live SDRAM write address.
REQ-015 sdram_rd_ptr  input  16  live SDRAM read address.
REQ-016 packet_size_rb  input  32  packet_size register from the CPU write block.
REQ-017 channel_rb  input  8  channel register from the CPU write block.

Function
REQ-018 The read-access start SHALL be the cycle where cpu_rd_n==0 and the registered previous cpu_rd_n==1; holding cpu_rd_n low SHALL NOT start further accesses.
REQ-019 On access start, cpu_rdata SHALL load the addressed value at the next edge, and cpu_rdata_valid SHALL pulse high for exactly that one cycle (latency 1).
REQ-020 cpu_rdata SHALL hold its value between accesses.
REQ-021 Map: 2 packet_size_rb; 13 {24'd0,channel_rb}; 16 VERSION; 20 {28'd0,err,rd_done,wr_done,tx_done} sticky; 21 {16'd0,sdram_wr_ptr}; 22 {16'd0,sdram_rd_ptr}; 23 tx packet counter; 24 error counter.
REQ-022 Any unmapped address SHALL return 32'd0 with no side effect.
REQ-023 Each sticky bit SHALL set on its input pulse and clear on an access start to address 20.
REQ-024 When a pulse coincides with the clearing read, the read SHALL return the pre-event value, and the bit SHALL remain set.
REQ-025 irq SHALL be the registered OR of the four sticky bits, asserting one cycle after the bit sets.
REQ-026 The tx counter (mac_tx_done) and the error counter (err_in) SHALL each be 32 bits, increment by 1 per pulse, and saturate at 32'hFFFF_FFFF without wrapping.
REQ-027 A counter SHALL clear to 0 on an access start to its own address.
REQ-028 When an increment coincides with a counter's clearing read, the read SHALL return the old value, and the counter SHALL become 1.
REQ-029 Reads of addresses 21 and 22 SHALL sample the pointers on the access-start cycle, with no synchronisation (same clock domain).

Reset
REQ-030 While nRST==0: cpu_rdata=0, cpu_rdata_valid=0, irq=0, sticky bits=0, counters=0, previous-strobe register=1.
REQ-031 Reset asserted mid-access SHALL abort the access with no side effects, and the first low cpu_rd_n after reset release SHALL count as an access start.

Configuration
REQ-032 Macro CPU_RD_COUNTERS_EN: when defined, addresses 23/24 and their counters SHALL be implemented per REQ-026..028.
REQ-033 When CPU_RD_COUNTERS_EN is undefined, no counter logic SHALL exist, and addresses 23/24 SHALL read 32'd0 without side effects.

Verification
REQ-034 Set packet_size_rb=32'h0000_05DC, then read address 2 -> cpu_rdata=32'h0000_05DC one cycle after access start, with cpu_rdata_valid high for exactly 1 cycle.
REQ-035 Hold cpu_rd_n low for 5 cycles on address 20 -> exactly one valid pulse and one clear.
REQ-036 Pulse sdram_wr_done -> irq=1, and address 20 reads 32'h2; an immediate re-read returns 0, and irq drops.
REQ-037 Pulse err_in on the same cycle as the address-20 access start, with status previously 0 -> read returns 0, and the next read returns 32'h8.
REQ-038 With CPU_RD_COUNTERS_EN defined, give 3 mac_tx_done pulses, then read address 23 with a concurrent pulse -> read returns 3, and the next read returns 1.
REQ-039 Force the error counter to 32'hFFFF_FFFE, then give 3 err_in pulses -> address 24 reads 32'hFFFF_FFFF.

Source files
------------

// File: rtl/cpu_read_con.sv
// NIOS read-side register block: edge-detected read strobe, registered read mux, sticky status with irq.
// Optional CPU_RD_COUNTERS_EN adds clear-on-read tx/error counters at addresses 23 and 24.
module cpu_read_con #(
  parameter logic [31:0] VERSION = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        cpu_rd_n,
  input  logic [8:0]  cpu_addr,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rdata_valid,
  output logic        irq,
  input  logic        mac_tx_done,
  input  logic        sdram_wr_done,
  input  logic        sdram_rd_done,
  input  logic        err_in,
  input  logic [15:0] sdram_wr_ptr,
  input  logic [15:0] sdram_rd_ptr,
  input  logic [31:0] packet_size_rb,
  input  logic [7:0]  channel_rb
);

  localparam logic [8:0] ADDR_PSIZE   = 9'd2;
  localparam logic [8:0] ADDR_CHANNEL = 9'd13;
  localparam logic [8:0] ADDR_VERSION = 9'd16;
  localparam logic [8:0] ADDR_STATUS  = 9'd20;
  localparam logic [8:0] ADDR_WR_PTR  = 9'd21;
  localparam logic [8:0] ADDR_RD_PTR  = 9'd22;
  localparam logic [8:0] ADDR_TX_CNT  = 9'd23;
  localparam logic [8:0] ADDR_ERR_CNT = 9'd24;

  logic        prev_rd_n;
  logic        rd_start;
  logic [3:0]  sticky;
  logic [3:0]  events;
  logic        status_clr;
  logic [31:0] rd_mux;

  // A held-low strobe starts only one access: start needs the previous strobe high.
  assign rd_start   = ~cpu_rd_n & prev_rd_n;
  assign events     = {err_in, sdram_rd_done, sdram_wr_done, mac_tx_done};
  assign status_clr = rd_start && (cpu_addr == ADDR_STATUS);

`ifdef CPU_RD_COUNTERS_EN
  logic [31:0] tx_cnt;
  logic [31:0] err_cnt;
  logic        tx_clr;
  logic        err_clr;

  assign tx_clr  = rd_start && (cpu_addr == ADDR_TX_CNT);
  assign err_clr = rd_start && (cpu_addr == ADDR_ERR_CNT);

  // A pulse coinciding with the clearing read is counted into the fresh value.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      tx_cnt <= 32'd0;
    end else if (tx_clr) begin
      tx_cnt <= {31'd0, mac_tx_done};
    end else if (mac_tx_done && (tx_cnt != 32'hFFFF_FFFF)) begin
      tx_cnt <= tx_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      err_cnt <= 32'd0;
    end else if (err_clr) begin
      err_cnt <= {31'd0, err_in};
    end else if (err_in && (err_cnt != 32'hFFFF_FFFF)) begin
      err_cnt <= err_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    rd_mux = 32'd0;
    case (cpu_addr)
      ADDR_PSIZE:   rd_mux = packet_size_rb;
      ADDR_CHANNEL: rd_mux = {24'd0, channel_rb};
      ADDR_VERSION: rd_mux = VERSION;
      ADDR_STATUS:  rd_mux = {28'd0, sticky};
      ADDR_WR_PTR:  rd_mux = {16'd0, sdram_wr_ptr};
      ADDR_RD_PTR:  rd_mux = {16'd0, sdram_rd_ptr};
`ifdef CPU_RD_COUNTERS_EN
      ADDR_TX_CNT:  rd_mux = tx_cnt;
      ADDR_ERR_CNT: rd_mux = err_cnt;
`endif
      default:      rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      prev_rd_n       <= 1'b1;
      cpu_rdata       <= 32'd0;
      cpu_rdata_valid <= 1'b0;
    end else begin
      prev_rd_n       <= cpu_rd_n;
      cpu_rdata_valid <= rd_start;
      if (rd_start) begin
        cpu_rdata <= rd_mux;
      end
    end
  end

  // Clear first, then set: a pulse on the clearing cycle keeps its bit set.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      sticky <= 4'd0;
      irq    <= 1'b0;
    end else begin
      sticky <= (status_clr ? 4'd0 : sticky) | events;
      irq    <= |sticky;
    end
  end

endmodule

// File: tb/tb_cpu_read_con.sv
// Bench for cpu_read_con: reset checks, a read-map vector table, directed corner sequences
// and a randomized run against a register-level reference model.
module tb_cpu_read_con;

  logic        clk;
  logic        nRST;
  logic        cpu_rd_n;
  logic [8:0]  cpu_addr;
  logic [31:0] cpu_rdata;
  logic        cpu_rdata_valid;
  logic        irq;
  logic        mac_tx_done;
  logic        sdram_wr_done;
  logic        sdram_rd_done;
  logic        err_in;
  logic [15:0] sdram_wr_ptr;
  logic [15:0] sdram_rd_ptr;
  logic [31:0] packet_size_rb;
  logic [7:0]  channel_rb;

  int tests_run = 0;
  int fails     = 0;

  cpu_read_con dut (
    .clk(clk), .nRST(nRST), .cpu_rd_n(cpu_rd_n), .cpu_addr(cpu_addr),
    .cpu_rdata(cpu_rdata), .cpu_rdata_valid(cpu_rdata_valid), .irq(irq),
    .mac_tx_done(mac_tx_done), .sdram_wr_done(sdram_wr_done),
    .sdram_rd_done(sdram_rd_done), .err_in(err_in),
    .sdram_wr_ptr(sdram_wr_ptr), .sdram_rd_ptr(sdram_rd_ptr),
    .packet_size_rb(packet_size_rb), .channel_rb(channel_rb)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  bit          m_prev;
  bit          m_tx, m_wr, m_rd, m_err;
  longint      m_tx_cnt, m_err_cnt;
  logic [31:0] m_rdata;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [8:0] a);
    case (a)
      9'd2:  return packet_size_rb;
      9'd13: return {24'd0, channel_rb};
      9'd16: return 32'h0000_0100;
      9'd20: return {28'd0, m_err, m_rd, m_wr, m_tx};
      9'd21: return {16'd0, sdram_wr_ptr};
      9'd22: return {16'd0, sdram_rd_ptr};
`ifdef CPU_RD_COUNTERS_EN
      9'd23: return m_tx_cnt[31:0];
      9'd24: return m_err_cnt[31:0];
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic longint bump(input longint c, input bit clr, input bit inc);
    longint r;
    r = clr ? 0 : c;
    if (inc && r < 64'h0000_0000_FFFF_FFFF) r = r + 1;
    return r;
  endfunction

  task automatic model_reset();
    m_prev = 1; m_tx = 0; m_wr = 0; m_rd = 0; m_err = 0;
    m_tx_cnt = 0; m_err_cnt = 0; m_rdata = 32'd0;
  endtask

  // One clock: predict, advance, compare, then drop the one-cycle pulses.
  task automatic step();
    bit          start;
    bit          irq_exp;
    logic [31:0] exp_d;
    start   = (cpu_rd_n == 1'b0) && m_prev;
    irq_exp = m_tx | m_wr | m_rd | m_err;
    exp_d   = m_rdata;
    if (start) exp_d = model_read(cpu_addr);
    if (start && cpu_addr == 9'd20) begin
      m_tx = 0; m_wr = 0; m_rd = 0; m_err = 0;
    end
    m_tx  = m_tx  | mac_tx_done;
    m_wr  = m_wr  | sdram_wr_done;
    m_rd  = m_rd  | sdram_rd_done;
    m_err = m_err | err_in;
    m_tx_cnt  = bump(m_tx_cnt,  start && cpu_addr == 9'd23, mac_tx_done);
    m_err_cnt = bump(m_err_cnt, start && cpu_addr == 9'd24, err_in);
    m_prev  = cpu_rd_n;
    m_rdata = exp_d;
    if (start) exp_q.push_back(exp_d);
    @(posedge clk); #1;
    check("valid", {31'd0, cpu_rdata_valid}, {31'd0, start});
    check("rdata", cpu_rdata, exp_d);
    check("irq", {31'd0, irq}, {31'd0, irq_exp});
    if (cpu_rdata_valid && exp_q.size() > 0) void'(exp_q.pop_front());
    mac_tx_done = 0; sdram_wr_done = 0; sdram_rd_done = 0; err_in = 0;
  endtask

  // Single access: strobe low one cycle, then idle one cycle.
  task automatic do_read(input logic [8:0] a, output logic [31:0] d);
    cpu_addr = a; cpu_rd_n = 1'b0;
    step();
    d = cpu_rdata;
    cpu_rd_n = 1'b1;
    step();
  endtask

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] psize;
    logic [7:0]  ch;
    logic [15:0] wp;
    logic [15:0] rp;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl[10];
  logic [31:0] d;
  int          valid_cnt;

  initial begin
    nRST = 0; cpu_rd_n = 1; cpu_addr = 0;
    mac_tx_done = 0; sdram_wr_done = 0; sdram_rd_done = 0; err_in = 0;
    sdram_wr_ptr = 16'h0; sdram_rd_ptr = 16'h0; packet_size_rb = 32'h0; channel_rb = 8'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_valid", {31'd0, cpu_rdata_valid}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk); nRST = 1;
    @(posedge clk); #1;

    // read-map vectors
    tbl[0] = '{9'd2,   32'h0000_05DC, 8'h11, 16'h0001, 16'h0002, 32'h0000_05DC};
    tbl[1] = '{9'd13,  32'h1234_5678, 8'hA5, 16'h0003, 16'h0004, 32'h0000_00A5};
    tbl[2] = '{9'd16,  32'hDEAD_BEEF, 8'h3C, 16'h0005, 16'h0006, 32'h0000_0100};
    tbl[3] = '{9'd21,  32'h0000_0001, 8'h00, 16'h1234, 16'h5678, 32'h0000_1234};
    tbl[4] = '{9'd22,  32'h0000_0002, 8'hFF, 16'hAAAA, 16'hBEEF, 32'h0000_BEEF};
    tbl[5] = '{9'd20,  32'hFFFF_FFFF, 8'h77, 16'hFFFF, 16'hFFFF, 32'h0000_0000};
    tbl[6] = '{9'd0,   32'hCAFE_F00D, 8'h01, 16'h0101, 16'h0202, 32'h0000_0000};
    tbl[7] = '{9'd3,   32'h8000_0000, 8'h80, 16'h8000, 16'h8000, 32'h0000_0000};
    tbl[8] = '{9'd511, 32'h5555_5555, 8'h55, 16'h5555, 16'h5555, 32'h0000_0000};
    tbl[9] = '{9'd23,  32'h0BAD_0BAD, 8'h42, 16'h4242, 16'h4242, 32'h0000_0000};
    for (int i = 0; i < 10; i++) begin
      packet_size_rb = tbl[i].psize; channel_rb = tbl[i].ch;
      sdram_wr_ptr = tbl[i].wp; sdram_rd_ptr = tbl[i].rp;
      do_read(tbl[i].addr, d);
      check($sformatf("tbl[%0d]", i), d, tbl[i].exp);
    end

    // latency 1, single valid pulse while strobe stays low
    packet_size_rb = 32'h0000_05DC;
    cpu_addr = 9'd2; cpu_rd_n = 0;
    step();
    check("psize_read", cpu_rdata, 32'h0000_05DC);
    check("psize_valid", {31'd0, cpu_rdata_valid}, 32'd1);
    step();
    check("psize_valid_drop", {31'd0, cpu_rdata_valid}, 32'd0);
    check("psize_hold", cpu_rdata, 32'h0000_05DC);
    cpu_rd_n = 1; step();

    // long strobe on status: one pulse, one clear
    sdram_rd_done = 1; step();
    cpu_addr = 9'd20; cpu_rd_n = 0; valid_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (cpu_rdata_valid) valid_cnt++;
    end
    check("long_strobe_pulses", valid_cnt, 1);
    check("long_strobe_data", cpu_rdata, 32'h4);
    cpu_rd_n = 1; step();
    do_read(9'd20, d);
    check("long_strobe_cleared", d, 32'h0);

    // wr_done: irq, read 2, re-read 0, irq drops
    sdram_wr_done = 1; step();
    step();
    check("irq_set", {31'd0, irq}, 32'd1);
    do_read(9'd20, d);
    check("status_wr", d, 32'h2);
    check("irq_dropped", {31'd0, irq}, 32'd0);
    do_read(9'd20, d);
    check("status_reread", d, 32'h0);

    // pulse on the clearing read survives
    cpu_addr = 9'd20; cpu_rd_n = 0; err_in = 1;
    step();
    check("coincide_read", cpu_rdata, 32'h0);
    cpu_rd_n = 1; step();
    do_read(9'd20, d);
    check("coincide_next", d, 32'h8);

`ifdef CPU_RD_COUNTERS_EN
    for (int i = 0; i < 3; i++) begin
      mac_tx_done = 1; step();
    end
    cpu_addr = 9'd23; cpu_rd_n = 0; mac_tx_done = 1;
    step();
    check("txcnt_read", cpu_rdata, 32'd3);
    cpu_rd_n = 1; step();
    do_read(9'd23, d);
    check("txcnt_next", d, 32'd1);

    @(negedge clk);
    force dut.err_cnt = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    release dut.err_cnt;
    m_err_cnt = 64'h0000_0000_FFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      err_in = 1; step();
    end
    do_read(9'd24, d);
    check("errcnt_saturate", d, 32'hFFFF_FFFF);
`else
    mac_tx_done = 1; err_in = 1; step();
    do_read(9'd23, d);
    check("no_txcnt", d, 32'h0);
    do_read(9'd24, d);
    check("no_errcnt", d, 32'h0);
`endif
    do_read(9'd20, d);

    // reset mid-access aborts; first low strobe after release starts a read
    sdram_wr_done = 1; step();
    cpu_addr = 9'd20; cpu_rd_n = 0;
    #2 nRST = 0;
    #1;
    check("midrst_rdata", cpu_rdata, 32'd0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    model_reset();
    sdram_wr_done = 0;
    @(negedge clk); nRST = 1;
    packet_size_rb = 32'h0000_0ABC; cpu_addr = 9'd2;
    step();
    check("post_rst_start", cpu_rdata, 32'h0000_0ABC);
    cpu_rd_n = 1; step();
    do_read(9'd20, d);
    check("post_rst_status", d, 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0: cpu_addr = 9'd2;
        1: cpu_addr = 9'd13;
        2: cpu_addr = 9'd16;
        3, 4: cpu_addr = 9'd20;
        5: cpu_addr = 9'd21;
        6: cpu_addr = 9'd22;
        7: cpu_addr = 9'd23;
        8: cpu_addr = 9'd24;
        default: cpu_addr = 9'($urandom_range(0, 511));
      endcase
      cpu_rd_n       = ($urandom_range(0, 2) != 0);
      mac_tx_done    = ($urandom_range(0, 5) == 0);
      sdram_wr_done  = ($urandom_range(0, 7) == 0);
      sdram_rd_done  = ($urandom_range(0, 7) == 0);
      err_in         = ($urandom_range(0, 9) == 0);
      sdram_wr_ptr   = 16'($urandom);
      sdram_rd_ptr   = 16'($urandom);
      packet_size_rb = $urandom;
      channel_rb     = 8'($urandom);
      step();
    end
    check("pending_reads", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
